// File: rtl/ps2_frame_rx_fifo.sv
// Serial keyboard frame receiver (start, LSB-first data, optional parity, stop)
// with inter-bit watchdog and a show-ahead FIFO of checked words.
module ps2_frame_rx_fifo #(
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 20000,
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              kb_negedge,
  input  logic              kb_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [CW-1:0]     fifo_count,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overflow,
  output logic              busy
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [WW-1:0] WD_LAST  = WW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [WW-1:0] WD_ONE   = WW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

  state_t              state_r, state_s;
  logic [BW-1:0]       bit_cnt_r;
  logic [DATA_W-1:0]   shreg_r;
  logic                par_ok_r;
  logic [WW-1:0]       wd_cnt_r;
  logic                perr_r, ferr_r, ovf_r;
  logic                push_s, perr_s, ferr_s, timeout_s;

  logic [DATA_W-1:0]   mem_r [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_r, rd_ptr_r, rd_ptr_s;
  logic [CW-1:0]       count_r, count_s;
  logic [DATA_W-1:0]   rd_data_r, head_s;
  logic                pop_s, full_s, wr_s, ovf_set_s;

  // True when the received parity bit completes the configured parity.
  function automatic logic parity_ok(input logic [DATA_W-1:0] word, input logic pbit);
    logic p;
    p = ^word ^ pbit;
    if (PARITY_MODE == 1) begin
      return p == 1'b1;
    end else begin
      return p == 1'b0;
    end
  endfunction

  // Frame FSM next state, error pulses and push request; a strobe beats the watchdog.
  always_comb begin
    state_s   = state_r;
    push_s    = 1'b0;
    perr_s    = 1'b0;
    ferr_s    = 1'b0;
    timeout_s = (TIMEOUT_CYC != 0) && (state_r != IDLE) && !kb_negedge && (wd_cnt_r == WD_LAST);
    if (kb_negedge) begin
      case (state_r)
        IDLE: begin
          if (!kb_data) state_s = DATA;
          else          state_s = IDLE;
        end
        DATA: begin
          if (bit_cnt_r == BIT_LAST) state_s = (PARITY_MODE != 0) ? PARITY : STOP;
          else                       state_s = DATA;
        end
        PARITY: state_s = STOP;
        STOP: begin
          state_s = IDLE;
          if (!kb_data)       ferr_s = 1'b1;
          else if (!par_ok_r) perr_s = 1'b1;
          else                push_s = 1'b1;
        end
        default: state_s = IDLE;
      endcase
    end else if (timeout_s) begin
      state_s = IDLE;
      ferr_s  = 1'b1;
    end else begin
      state_s = state_r;
    end
  end

  // FSM state, shift register, parity flag, watchdog counter and error pulses.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_r   <= IDLE;
      bit_cnt_r <= '0;
      shreg_r   <= '0;
      par_ok_r  <= 1'b1;
      wd_cnt_r  <= '0;
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      perr_r  <= perr_s;
      ferr_r  <= ferr_s;
      if (kb_negedge || state_r == IDLE) wd_cnt_r <= '0;
      else                               wd_cnt_r <= wd_cnt_r + WD_ONE;
      if (kb_negedge) begin
        case (state_r)
          IDLE: begin
            bit_cnt_r <= '0;
            par_ok_r  <= 1'b1;
          end
          DATA: begin
            shreg_r[bit_cnt_r] <= kb_data;
            if (bit_cnt_r != BIT_LAST) bit_cnt_r <= bit_cnt_r + BIT_ONE;
          end
          PARITY:  par_ok_r <= parity_ok(shreg_r, kb_data);
          default: ;
        endcase
      end
    end
  end

  // FIFO bookkeeping; a push into a full FIFO succeeds only if the head leaves the same cycle.
  always_comb begin
    pop_s     = rd_en && (count_r != '0);
    full_s    = (count_r == CNT_FULL);
    wr_s      = push_s && (!full_s || pop_s);
    ovf_set_s = push_s && full_s && !pop_s;
    rd_ptr_s  = pop_s ? rd_ptr_r + PTR_ONE : rd_ptr_r;
    if (wr_s && !pop_s)      count_s = count_r + CNT_ONE;
    else if (pop_s && !wr_s) count_s = count_r - CNT_ONE;
    else                     count_s = count_r;
    if (count_s == '0)                      head_s = '0;
    else if (wr_s && wr_ptr_r == rd_ptr_s)  head_s = shreg_r;
    else                                    head_s = mem_r[rd_ptr_s];
  end

  // FIFO storage.
  always_ff @(posedge sys_clk) begin
    if (wr_s) mem_r[wr_ptr_r] <= shreg_r;
  end

  // FIFO pointers, count, registered head and sticky overflow.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      rd_data_r <= '0;
      ovf_r     <= 1'b0;
    end else begin
      if (wr_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      rd_ptr_r  <= rd_ptr_s;
      count_r   <= count_s;
      rd_data_r <= head_s;
      if (ovf_set_s) ovf_r <= 1'b1;
    end
  end

  assign rd_data    = rd_data_r;
  assign fifo_count = count_r;
  assign fifo_empty = (count_r == '0);
  assign fifo_full  = (count_r == CNT_FULL);
  assign parity_err = perr_r;
  assign frame_err  = ferr_r;
  assign overflow   = ovf_r;
  assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_ps2_frame_rx_fifo.sv
// Bench for ps2_frame_rx_fifo: frame-level reference model with a per-cycle
// compare process, directed scenarios with literal expectations, random traffic.
module tb_ps2_frame_rx_fifo;
  localparam int DW    = 8;
  localparam int PM    = 1;
  localparam int DEPTH = 4;
  localparam int TO    = 50;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int FRAME_BITS = DW + ((PM != 0) ? 1 : 0) + 1;

  logic          sys_clk = 1'b0;
  logic          reset = 1'b1;
  logic          kb_negedge = 1'b0;
  logic          kb_data = 1'b1;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          fifo_empty, fifo_full, parity_err, frame_err, overflow, busy;
  logic [CW-1:0] fifo_count;

  ps2_frame_rx_fifo #(.DATA_W(DW), .PARITY_MODE(PM), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .sys_clk(sys_clk), .reset(reset), .kb_negedge(kb_negedge), .kb_data(kb_data),
    .rd_en(rd_en), .rd_data(rd_data), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_count(fifo_count), .parity_err(parity_err), .frame_err(frame_err),
    .overflow(overflow), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit rand_rd = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects whole frames, then judges them.
  logic [DW-1:0] q[$];
  bit  in_frame = 1'b0;
  int  nbits = 0;
  int  since = 0;
  bit  bits[FRAME_BITS];
  bit  m_perr = 1'b0, m_ferr = 1'b0, m_ovf = 1'b0;
  bit  chk_en = 1'b0;

  always @(posedge sys_clk) begin
    bit push, pop;
    logic [DW-1:0] word;
    int ones;
    push = 1'b0;
    word = '0;
    if (reset) begin
      in_frame = 1'b0; nbits = 0; since = 0; q.delete();
      m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0; chk_en = 1'b1;
    end else begin
      m_perr = 1'b0; m_ferr = 1'b0;
      if (kb_negedge) begin
        since = 0;
        if (!in_frame) begin
          if (!kb_data) begin in_frame = 1'b1; nbits = 0; end
        end else begin
          bits[nbits] = kb_data;
          nbits++;
          if (nbits == FRAME_BITS) begin
            in_frame = 1'b0;
            ones = 0;
            for (int i = 0; i < DW; i++) begin
              word[i] = bits[i];
              ones += int'(bits[i]);
            end
            if (PM != 0) ones += int'(bits[DW]);
            if (!bits[FRAME_BITS-1])          m_ferr = 1'b1;
            else if (PM == 1 && ones % 2 == 0) m_perr = 1'b1;
            else if (PM == 2 && ones % 2 == 1) m_perr = 1'b1;
            else                               push = 1'b1;
          end
        end
      end else if (in_frame) begin
        since++;
        if (TO != 0 && since == TO) begin in_frame = 1'b0; m_ferr = 1'b1; end
      end
      pop = rd_en && (q.size() > 0);
      if (push && q.size() == DEPTH && !pop) m_ovf = 1'b1;
      if (pop) void'(q.pop_front());
      if (push && !(q.size() == DEPTH)) q.push_back(word);
    end
  end

  // Compare process: every cycle after the first reset edge.
  always @(negedge sys_clk) begin
    if (chk_en) begin
      chk("rd_data",    int'(rd_data),    (q.size() > 0) ? int'(q[0]) : 0);
      chk("fifo_count", int'(fifo_count), q.size());
      chk("fifo_empty", int'(fifo_empty), int'(q.size() == 0));
      chk("fifo_full",  int'(fifo_full),  int'(q.size() == DEPTH));
      chk("parity_err", int'(parity_err), int'(m_perr));
      chk("frame_err",  int'(frame_err),  int'(m_ferr));
      chk("overflow",   int'(overflow),   int'(m_ovf));
      chk("busy",       int'(busy),       int'(in_frame));
    end
  end

  function automatic logic rdv();
    return rand_rd ? ($urandom_range(0, 2) == 0) : 1'b0;
  endfunction

  task automatic step(input logic s, input logic d, input logic r);
    kb_negedge = s; kb_data = d; rd_en = r;
    @(negedge sys_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)), rdv());
  endtask

  task automatic send_bit(input logic b, input int gap);
    idle(gap);
    step(1'b1, b, rdv());
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input bit bad_par, input logic stop, input bit rd_stop);
    send_bit(1'b0, 2);
    for (int i = 0; i < DW; i++) send_bit(d[i], 2);
    send_bit((~^d) ^ bad_par, 2);
    idle(2);
    step(1'b1, stop, rd_stop ? 1'b1 : rdv());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    reset = 1'b0;
  endtask

  function automatic int rgap();
    return ($urandom_range(0, 24) == 0) ? int'($urandom_range(45, 55)) : int'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [DW-1:0] d;
    int k;
    do_reset();
    chk("rst_empty", int'(fifo_empty), 1);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_busy", int'(busy), 0);

    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    chk("good_rd_data", int'(rd_data), 'h1C);
    chk("good_count", int'(fifo_count), 1);
    chk("good_perr", int'(parity_err), 0);
    step(1'b0, 1'b1, 1'b1);
    chk("pop_empty", int'(fifo_empty), 1);

    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    chk("bad_par_pulse", int'(parity_err), 1);
    chk("bad_par_count", int'(fifo_count), 0);
    step(1'b0, 1'b1, 1'b0);
    chk("bad_par_end", int'(parity_err), 0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    chk("bad_stop_pulse", int'(frame_err), 1);
    chk("bad_stop_count", int'(fifo_count), 0);

    send_bit(1'b0, 2);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 2);
    for (int i = 0; i < TO - 1; i++) step(1'b0, 1'b1, 1'b0);
    chk("to_not_yet", int'(frame_err), 0);
    step(1'b0, 1'b1, 1'b0);
    chk("to_pulse", int'(frame_err), 1);
    chk("to_busy", int'(busy), 0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    chk("after_to_data", int'(rd_data), 'h5A);
    step(1'b0, 1'b1, 1'b1);

    for (int i = 1; i <= 5; i++) send_frame(DW'(i), 1'b0, 1'b1, 1'b0);
    chk("ovf_full", int'(fifo_full), 1);
    chk("ovf_flag", int'(overflow), 1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_read", int'(rd_data), i);
      step(1'b0, 1'b1, 1'b1);
    end
    chk("ovf_drained", int'(fifo_empty), 1);

    do_reset();
    for (int i = 0; i < 4; i++) send_frame(DW'(8'h11 + i), 1'b0, 1'b1, 1'b0);
    send_frame(8'h16, 1'b0, 1'b1, 1'b1);
    chk("pp_ovf", int'(overflow), 0);
    chk("pp_count", int'(fifo_count), 4);
    chk("pp_head", int'(rd_data), 'h12);

    send_bit(1'b0, 2);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 2);
    reset = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_empty", int'(fifo_empty), 1);
    chk("mid_rst_ferr", int'(frame_err), 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    chk("idle_ones_busy", int'(busy), 0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    chk("f0_data", int'(rd_data), 'hF0);

    rand_rd = 1'b1;
    for (int f = 0; f < 300; f++) begin
      if ($urandom_range(0, 5) == 0) send_bit(1'b1, rgap());
      d = DW'($urandom);
      k = ($urandom_range(0, 14) == 0) ? int'($urandom_range(1, FRAME_BITS - 1)) : FRAME_BITS;
      send_bit(1'b0, rgap());
      for (int i = 0; i < k; i++) begin
        if (i < DW)       send_bit(d[i], rgap());
        else if (i == DW) send_bit((~^d) ^ ($urandom_range(0, 7) == 0), rgap());
        else              send_bit($urandom_range(0, 9) != 0, rgap());
      end
      if (k < FRAME_BITS) idle(TO + 2);
    end
    rand_rd = 1'b0;
    idle(TO + 2);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, 1'b1);
    chk("final_empty", int'(fifo_empty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
